// File: rtl/kbd_seq_ctrl.sv
// PS/2 scan-code sequencer: byte FIFO feeding a make/break/extended parser; outputs register 2 cycles after the strobe.
// i_hold stalls pops only; a strobe arriving while the FIFO is full with no pop is dropped and latches o_overflow.
module kbd_seq_ctrl #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_hold,
  output logic [7:0]       o_key,
  output logic             o_ext,
  output logic             o_is_press,
  output logic [CNT_W-1:0] o_count,
  output logic             o_key_evt,
  output logic             o_err,
  output logic             o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  state_t        r_state;
  logic [TW-1:0] r_tmo;

  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [7:0] w_byte;
  logic       w_repeat;
  logic       w_rel_match;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = !w_empty && !i_hold;
  // A full FIFO still takes the byte when a pop frees a slot in the same cycle.
  assign w_push  = i_rx_valid && (!w_full || w_pop);
  assign w_drop  = i_rx_valid && w_full && !w_pop;
  assign w_byte  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_repeat    = o_is_press && (o_key == w_byte) && (o_ext == (r_state == S_EXT));
  assign w_rel_match = o_is_press && (o_key == w_byte) && (o_ext == (r_state == S_EXT_BRK));

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      o_key      <= 8'h00;
      o_ext      <= 1'b0;
      o_is_press <= 1'b0;
      o_count    <= '0;
      o_key_evt  <= 1'b0;
      o_err      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_key_evt <= 1'b0;
      o_err     <= 1'b0;
      if (w_drop) o_overflow <= 1'b1;
      if (w_pop) begin
        r_tmo <= '0;
        case (r_state)
          S_IDLE, S_EXT: begin
            if (w_byte == BRK_CODE) begin
              r_state <= (r_state == S_IDLE) ? S_BRK : S_EXT_BRK;
            end else if (w_byte == EXT_CODE) begin
              if (r_state == S_IDLE) begin
                r_state <= S_EXT;
              end else begin
                r_state <= S_IDLE;
                o_err   <= 1'b1;
              end
            end else begin
              r_state <= S_IDLE;
              // Typematic repeats of the held key produce no event.
              if (!w_repeat) begin
                o_key      <= w_byte;
                o_ext      <= (r_state == S_EXT);
                o_is_press <= 1'b1;
                o_count    <= o_count + CNT_W'(1);
                o_key_evt  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            if (w_byte == BRK_CODE || w_byte == EXT_CODE) begin
              o_err <= 1'b1;
            end else if (w_rel_match) begin
              o_is_press <= 1'b0;
              o_key_evt  <= 1'b1;
            end
          end
        endcase
      end else if (r_state == S_IDLE) begin
        r_tmo <= '0;
      end else if (!i_hold) begin
        if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
          r_tmo   <= '0;
          r_state <= S_IDLE;
          o_err   <= 1'b1;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_kbd_seq_ctrl.sv
// Bench for kbd_seq_ctrl: directed scenarios plus random traffic against a queue-based parser model.
module tb_kbd_seq_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int TMO   = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             hold = 1'b0;
  logic [7:0]       key;
  logic             ext, is_press, key_evt, err, overflow;
  logic [CNT_W-1:0] count;

  kbd_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_hold(hold),
    .o_key(key), .o_ext(ext), .o_is_press(is_press), .o_count(count),
    .o_key_evt(key_evt), .o_err(err), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: bytes queue up, one is consumed per unheld cycle, and the scan-code rules apply to it.
  logic [7:0]       q[$];
  logic [7:0]       m_key, m_b;
  logic             m_ext, m_press, m_evt, m_err, m_ovf, m_pop;
  logic [CNT_W-1:0] m_cnt;
  int               m_st;   // 0 idle, 1 after F0, 2 after E0, 3 after E0 F0
  int               m_idle;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_key = 8'h00; m_ext = 0; m_press = 0; m_cnt = '0;
      m_evt = 0; m_err = 0; m_ovf = 0; m_st = 0; m_idle = 0;
    end else begin
      m_evt = 0; m_err = 0;
      m_pop = (q.size() != 0) && !hold;
      if (m_pop) begin
        m_b = q.pop_front();
        m_idle = 0;
        if (m_st == 0 || m_st == 2) begin
          if (m_b == 8'hF0) m_st = m_st + 1;
          else if (m_b == 8'hE0) begin
            if (m_st == 0) m_st = 2;
            else begin m_err = 1; m_st = 0; end
          end else begin
            if (!(m_press && m_key == m_b && m_ext == (m_st == 2))) begin
              m_key = m_b; m_ext = (m_st == 2); m_press = 1; m_cnt = m_cnt + 1'b1; m_evt = 1;
            end
            m_st = 0;
          end
        end else begin
          if (m_b == 8'hF0 || m_b == 8'hE0) m_err = 1;
          else if (m_press && m_key == m_b && m_ext == (m_st == 3)) begin m_press = 0; m_evt = 1; end
          m_st = 0;
        end
      end else if (m_st != 0 && !hold) begin
        m_idle++;
        if (m_idle == TMO) begin m_err = 1; m_st = 0; m_idle = 0; end
      end
      if (rx_valid) begin
        if (q.size() < DEPTH) q.push_back(rx_data);
        else m_ovf = 1;
      end
    end
  end

  // Cycle monitor: event counters and a full output compare against the model.
  bit          mon_en = 0;
  int          n_evt = 0, n_errp = 0, n_both = 0, n_mm = 0;
  time         mm_time;
  logic [22:0] mm_dut, mm_exp;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (key_evt) n_evt++;
      if (err) n_errp++;
      if (key_evt && err) n_both++;
      if ({key, ext, is_press, count, key_evt, err, overflow} !==
          {m_key, m_ext, m_press, m_cnt, m_evt, m_err, m_ovf}) begin
        if (n_mm == 0) begin
          mm_time = $time;
          mm_dut = {key, ext, is_press, count, key_evt, err, overflow};
          mm_exp = {m_key, m_ext, m_press, m_cnt, m_evt, m_err, m_ovf};
        end
        n_mm++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns key_evt just after the sampling edge and one edge later.
  task automatic strobe_timed(input logic [7:0] b, output logic e0, output logic e1);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1 e0 = key_evt;
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #1 e1 = key_evt;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if ({key, ext, is_press, count} !== 18'h0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", {key, ext, is_press, count}); end
    n_chk++; if ({key_evt, err, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b want=000", {key_evt, err, overflow}); end
  endtask

  task automatic test_make_break();
    logic e0, e1;
    do_reset();
    strobe_timed(8'h1C, e0, e1);
    n_chk++; if ({e0, e1} !== 2'b01) begin n_fail++; $display("FAIL make_evt_timing got=%b want=01", {e0, e1}); end
    n_chk++; if ({key, ext, is_press, count} !== {8'h1C, 1'b0, 1'b1, 8'd1}) begin n_fail++; $display("FAIL make_state got=%h/%b/%b/%0d want=1c/0/1/1", key, ext, is_press, count); end
    strobe(8'hF0);
    strobe_timed(8'h1C, e0, e1);
    n_chk++; if ({e0, e1} !== 2'b01) begin n_fail++; $display("FAIL break_evt_timing got=%b want=01", {e0, e1}); end
    n_chk++; if ({key, is_press, count} !== {8'h1C, 1'b0, 8'd1}) begin n_fail++; $display("FAIL break_state got=%h/%b/%0d want=1c/0/1", key, is_press, count); end
  endtask

  task automatic test_repeat();
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    int ev0;
    do_reset();
    ev0 = n_evt;
    for (int i = 0; i < 5; i++) begin @(negedge clk); rx_valid = 1'b1; rx_data = seq[i]; end
    @(negedge clk); rx_valid = 1'b0;
    idle(6);
    n_chk++; if (count !== 8'd1) begin n_fail++; $display("FAIL repeat_count got=%0d want=1", count); end
    n_chk++; if (n_evt - ev0 !== 2) begin n_fail++; $display("FAIL repeat_evts got=%0d want=2", n_evt - ev0); end
    n_chk++; if (is_press !== 1'b0) begin n_fail++; $display("FAIL repeat_release got=%b want=0", is_press); end
  endtask

  task automatic test_extended();
    do_reset();
    strobe(8'hE0); strobe(8'h75); idle(2);
    n_chk++; if ({key, ext, is_press, count} !== {8'h75, 1'b1, 1'b1, 8'd1}) begin n_fail++; $display("FAIL ext_make got=%h/%b/%b/%0d want=75/1/1/1", key, ext, is_press, count); end
    strobe(8'hF0); strobe(8'h75); idle(2);
    n_chk++; if (is_press !== 1'b1) begin n_fail++; $display("FAIL ext_plain_break got=%b want=1", is_press); end
    strobe(8'hE0); strobe(8'hF0); strobe(8'h75); idle(2);
    n_chk++; if ({key, ext, is_press, count} !== {8'h75, 1'b1, 1'b0, 8'd1}) begin n_fail++; $display("FAIL ext_break got=%h/%b/%b/%0d want=75/1/0/1", key, ext, is_press, count); end
  endtask

  task automatic test_bad_release();
    int ev0, er0;
    do_reset();
    ev0 = n_evt; er0 = n_errp;
    strobe(8'h1C); strobe(8'hF0); strobe(8'h32); idle(2);
    n_chk++; if (is_press !== 1'b1 || n_evt - ev0 !== 1) begin n_fail++; $display("FAIL nonheld_release press=%b evts=%0d want=1/1", is_press, n_evt - ev0); end
    strobe(8'hF0); strobe(8'hF0); idle(2);
    n_chk++; if (n_errp - er0 !== 1) begin n_fail++; $display("FAIL double_f0_err got=%0d want=1", n_errp - er0); end
    strobe(8'h32); idle(2);
    n_chk++; if ({key, count} !== {8'h32, 8'd2}) begin n_fail++; $display("FAIL after_err_make got=%h/%0d want=32/2", key, count); end
  endtask

  task automatic test_overflow();
    logic [7:0] seq [6] = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hE0, 8'h75};
    int ev0;
    do_reset();
    ev0 = n_evt;
    @(negedge clk); hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = seq[i];
      @(posedge clk); #1;
      if (i == 3) begin n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b want=0", overflow); end end
      if (i == 4) begin n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want=1", overflow); end end
    end
    @(negedge clk); rx_valid = 1'b0;
    idle(3);
    n_chk++; if (n_evt != ev0) begin n_fail++; $display("FAIL hold_stalls got=%0d want=0", n_evt - ev0); end
    hold = 1'b0;
    idle(8);
    n_chk++; if ({key, ext, is_press, count} !== {8'h32, 1'b0, 1'b1, 8'd2} || n_evt - ev0 !== 3) begin n_fail++; $display("FAIL ovf_drain got=%h/%b/%b/%0d evts=%0d want=32/0/1/2 evts=3", key, ext, is_press, count, n_evt - ev0); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_timeout();
    int er0;
    do_reset();
    er0 = n_errp;
    strobe(8'hF0);
    idle(TMO + 5);
    n_chk++; if (n_errp - er0 !== 1) begin n_fail++; $display("FAIL timeout_err got=%0d want=1", n_errp - er0); end
    strobe(8'h1C); idle(2);
    n_chk++; if ({key, is_press, count} !== {8'h1C, 1'b1, 8'd1}) begin n_fail++; $display("FAIL after_timeout got=%h/%b/%0d want=1c/1/1", key, is_press, count); end
  endtask

  task automatic test_back_to_back_wrap();
    int ev0;
    do_reset();
    ev0 = n_evt;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = (i % 2 == 0) ? 8'h1C : 8'h32;
    end
    @(negedge clk); rx_valid = 1'b0;
    idle(4);
    n_chk++; if (count !== 8'h00) begin n_fail++; $display("FAIL wrap_count got=%h want=00", count); end
    n_chk++; if (n_evt - ev0 !== 256) begin n_fail++; $display("FAIL wrap_evts got=%0d want=256", n_evt - ev0); end
    n_chk++; if ({key, overflow} !== {8'h32, 1'b0}) begin n_fail++; $display("FAIL wrap_last got=%h/%b want=32/0", key, overflow); end
  endtask

  task automatic test_random();
    logic [7:0] pool [5] = '{8'h1C, 8'h32, 8'h75, 8'hF0, 8'hE0};
    int sel;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      @(negedge clk);
      if (i % 200 == 150) begin
        rx_valid = 1'b0; hold = 1'b0;
        idle(TMO + 3);
      end
      sel = $urandom_range(0, 5);
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data = (sel == 5) ? 8'($urandom_range(0, 255)) : pool[sel];
      hold = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk); rx_valid = 1'b0; hold = 1'b0;
    idle(8);
    n_chk++; if ({key, ext, is_press, count} !== {m_key, m_ext, m_press, m_cnt}) begin n_fail++; $display("FAIL random_final got=%h/%b/%b/%h want=%h/%b/%b/%h", key, ext, is_press, count, m_key, m_ext, m_press, m_cnt); end
  endtask

  task automatic test_model_trace();
    n_chk++; if (n_mm !== 0) begin n_fail++; $display("FAIL cycle_trace mismatches=%0d first@%0t got=%h want=%h", n_mm, mm_time, mm_dut, mm_exp); end
    n_chk++; if (n_both !== 0) begin n_fail++; $display("FAIL evt_err_overlap got=%0d want=0", n_both); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_repeat();
    test_extended();
    test_bad_release();
    test_overflow();
    test_timeout();
    test_back_to_back_wrap();
    test_random();
    test_model_trace();
    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/kbd_seq_ctrl.md
# kbd_seq_ctrl

Sequencer between the PS/2 frame receiver and the display datapath (scan-code to ASCII lookup and 7-segment decoders). Buffers received scan-code bytes in a small FIFO and parses make, break (`F0`) and extended (`E0`) prefixes with an FSM. Drives the held-key code, press state, extended flag and a press counter. Suppresses typematic repeats and recovers from truncated sequences by timeout.

## Interface
- `DEPTH`, 4: byte FIFO depth, power of two, at least 2.
- `CNT_W`, 8: press-counter width.
- `TIMEOUT_CYC`, 2_000_000: idle cycles allowed inside a prefix sequence (40 ms at 50 MHz).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received scan-code byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid while high.
- `hold` in 1: while high, the FIFO does not pop; pushes continue.
- `key` out 8: last make code accepted.
- `ext` out 1: `key` came from an `E0`-prefixed make.
- `is_press` out 1: `key` is currently held.
- `count` out `CNT_W`: number of distinct presses accepted, wraps.
- `key_evt` out 1: one-cycle pulse on each accepted press or release.
- `err` out 1: one-cycle pulse on a protocol error or timeout.
- `overflow` out 1: sticky; a byte was dropped. Cleared only by reset.

## Operation
- FIFO push when `rx_valid`=1 and the FIFO is not full.
- If the FIFO is full and no pop occurs that cycle, the byte is dropped and `overflow` is set.
- Full with a simultaneous pop: the push is accepted.
- Pop whenever the FIFO is non-empty and `hold`=0. At most one byte is popped per cycle.
- FSM states: IDLE, BRK (saw `F0`), EXT (saw `E0`), EXT_BRK (saw `E0 F0`).
- IDLE, popped byte:
  - `F0` → BRK.
  - `E0` → EXT.
  - Otherwise this is a make. If `is_press`=1, `ext`=0 and `key`=byte, it is a typematic repeat: ignore it.
  - Any other make: `key`←byte, `ext`←0, `is_press`←1, `count`←`count`+1 (modulo 2^`CNT_W`), `key_evt` pulse.
- BRK, popped byte:
  - `F0` or `E0`: `err` pulse, → IDLE.
  - Byte equals `key` with `ext`=0 and `is_press`=1: `is_press`←0, `key_evt` pulse.
  - Any other byte: release of a non-held key; no output change.
  - All non-error cases → IDLE.
- EXT, popped byte:
  - `F0` → EXT_BRK.
  - `E0`: `err` pulse, → IDLE.
  - Otherwise this is an extended make. It follows the IDLE make rules with `ext`←1; the repeat check requires `ext`=1. → IDLE.
- EXT_BRK: same as BRK, except the release match requires `ext`=1.
- Timeout:
  - The counter is active only in BRK, EXT and EXT_BRK. It clears on every pop and in IDLE.
  - It does not count while `hold`=1.
  - On reaching `TIMEOUT_CYC`: `err` pulse, → IDLE, outputs unchanged.
- Reset clears FIFO pointers, the FSM (to IDLE), the timeout counter and every output. Reset applied mid-sequence discards any buffered or partial bytes.

## Timing
- Reset values: `key`=0x00, `ext`=0, `is_press`=0, `count`=0, `key_evt`=0, `err`=0, `overflow`=0.
- A byte strobed at edge N is written at N and popped at N+1 (if `hold`=0). Resulting outputs are registered at N+1 and visible after edge N+1.
- Latency from strobe to output change is 2 cycles.
- `key_evt` and `err` are high for exactly one cycle and are never high in the same cycle.
- `key`, `ext`, `is_press` and `count` change in the same cycle as the `key_evt` pulse, and only then.
- `overflow` is set in the cycle after the dropped strobe.
- Back-to-back strobes on every cycle are sustained without loss when `hold`=0.

## Test plan
- Bytes `1C`, `F0`, `1C`:
  - `key`=0x1C, `ext`=0, `count`=1.
  - `is_press` goes 1 then 0.
  - Two `key_evt` pulses; each lands 2 cycles after its byte.
- Bytes `1C`, `1C`, `1C`, `F0`, `1C`: `count`=1, `key_evt` pulses exactly twice.
- Bytes `E0`, `75`, `E0`, `F0`, `75`:
  - `key`=0x75, `ext`=1, `count`+1.
  - Final `is_press`=0.
  - A plain `F0 75` sent before the extended release does not clear `is_press`.
- Bytes `1C`, `F0`, `32`: `is_press` stays 1, one `key_evt` only. Then `F0`, `F0`: one `err` pulse, state IDLE.
- With `hold`=1, strobe 6 bytes:
  - FIFO holds the first 4; `overflow`=1.
  - Release `hold`: exactly 4 bytes are processed in order.
- Byte `F0` then silence for `TIMEOUT_CYC` cycles: `err` pulses once. Next byte `1C` is accepted as a make and `count` increments.
- 256 distinct alternating makes (`1C`/`32`) with `CNT_W`=8: `count` wraps to 0x00.
